// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD value display controller:
// FSM encoding, the 9-bit {rs, data} transfer word and the digit-to-character mapping.
package lcd_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LATCH,
      S_CONVERT,
      S_LOAD,
      S_ISSUE,
      S_WAIT_HI,
      S_WAIT_LO,
      S_NEXT,
      S_DONE
   } disp_state_e;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_xfer_t;

   localparam logic       RS_CMD       = 1'b0;
   localparam logic       RS_DATA      = 1'b1;
   localparam logic [7:0] ASCII_DIGIT0 = 8'h30;
   localparam logic [7:0] ASCII_SPACE  = 8'h20;
   localparam logic [7:0] DDRAM_LINE1  = 8'h80;
   localparam logic [7:0] DDRAM_LINE2  = 8'hC0;

   localparam int         NUM_DIGITS = 10;
   localparam int         BIN_W      = 32;
   localparam int         BCD_W      = 4 * NUM_DIGITS;
   localparam logic [3:0] LAST_IDX   = 4'd10;

   // Character for transfer index 1..10 (most significant digit first). A digit is
   // "leading" while every digit up to and including it is zero; the units digit never is.
   function automatic lcd_xfer_t digit_xfer(input logic [BCD_W-1:0] bcd,
                                            input logic [3:0]       idx,
                                            input logic             blank_lead);
      lcd_xfer_t  x;
      logic       leading;
      logic [3:0] dig;
      leading = 1'b1;
      dig     = 4'd0;
      for (int k = 1; k <= NUM_DIGITS; k++) begin
         if (4'(k) <= idx) begin
            dig = bcd[(NUM_DIGITS-k)*4 +: 4];
            if (dig != 4'd0 || k == NUM_DIGITS) leading = 1'b0;
         end
      end
      x.rs   = RS_DATA;
      x.data = (blank_lead && leading) ? ASCII_SPACE : (ASCII_DIGIT0 + {4'd0, dig});
      return x;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: loads on start, then performs one add-3/shift
// step per cycle; done is high during the 32nd step so bcd is final on the next cycle.
module bin2bcd_seq
   import lcd_pkg::*;
(
   input  logic             clock,
   input  logic             internal_reset_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic [BCD_W-1:0] bcd,
   output logic             done
);

   logic [BIN_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d, adj;
   logic [4:0]       cnt_q, cnt_d;
   logic             act_q, act_d;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] > 4'd4) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end

      bin_d = bin_q;
      bcd_d = bcd_q;
      cnt_d = cnt_q;
      act_d = act_q;
      if (start) begin
         bin_d = bin;
         bcd_d = '0;
         cnt_d = '0;
         act_d = 1'b1;
      end else if (act_q) begin
         {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
         cnt_d          = cnt_q + 5'd1;
         if (cnt_q == 5'd31) act_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge internal_reset_n) begin
      if (!internal_reset_n) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
         act_q <= 1'b0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
         act_q <= act_d;
      end
   end

   assign bcd  = bcd_q;
   assign done = act_q && (cnt_q == 5'd31);

endmodule

// File: rtl/lcd_value_display.sv
// Periodic refresh controller: on each tick snapshots value, converts it to BCD and
// writes a cursor command plus ten right-aligned decimal characters through the lcd core.
module lcd_value_display
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned REFRESH_MS = 250,
   parameter logic [7:0]  POS_CMD    = DDRAM_LINE2,
   parameter bit          BLANK_LEAD = 1'b1
)(
   input  logic       clock,
   input  logic       internal_reset_n,
   input  logic       enable,
   input  logic [31:0] value,
   input  logic       lcd_busy,
   output logic [8:0] lcd_d_in,
   output logic       lcd_data_ready,
   output logic       frame_busy,
   output logic       frame_done
);

   localparam int unsigned      PERIOD   = CLK_FREQ / 1000 * REFRESH_MS;
   localparam int               CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             tick_pend_q, tick_pend_d;
   logic             take_tick;

   disp_state_e      state_q;
   logic [3:0]       idx_q;
   lcd_xfer_t        xfer_q, load_xfer;
   logic             data_ready_q, frame_busy_q, frame_done_q;

   logic             conv_done;
   logic [BCD_W-1:0] bcd;

   // A tick arriving in the same cycle the FSM consumes the pending flag wins, so it is not lost.
   assign take_tick = (state_q == S_IDLE) && tick_pend_q;

   always_comb begin
      tick_cnt_d  = tick_cnt_q;
      tick_pend_d = tick_pend_q && !take_tick;
      if (!enable) begin
         tick_cnt_d  = '0;
         tick_pend_d = 1'b0;
      end else if (tick_cnt_q == CNT_LAST) begin
         tick_cnt_d  = '0;
         tick_pend_d = 1'b1;
      end else begin
         tick_cnt_d  = tick_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge internal_reset_n) begin
      if (!internal_reset_n) begin
         tick_cnt_q  <= '0;
         tick_pend_q <= 1'b0;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         tick_pend_q <= tick_pend_d;
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clock            (clock),
      .internal_reset_n (internal_reset_n),
      .start            (state_q == S_LATCH),
      .bin              (value),
      .bcd              (bcd),
      .done             (conv_done)
   );

   always_comb begin
      load_xfer = digit_xfer(bcd, idx_q, BLANK_LEAD);
      if (idx_q == 4'd0) begin
         load_xfer.rs   = RS_CMD;
         load_xfer.data = POS_CMD;
      end
   end

   // Handshake with the core: a transfer is requested by a one-cycle data_ready pulse, only
   // when busy_flag is low; it is complete once busy_flag has been seen high and then low
   // again. lcd_d_in is held from LOAD until that completion.
   always_ff @(posedge clock or negedge internal_reset_n) begin
      if (!internal_reset_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         xfer_q       <= '0;
         data_ready_q <= 1'b0;
         frame_busy_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         data_ready_q <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (tick_pend_q) begin
                  frame_busy_q <= 1'b1;
                  state_q      <= S_LATCH;
               end
            end
            S_LATCH:   state_q <= S_CONVERT;
            S_CONVERT: begin
               if (conv_done) begin
                  idx_q   <= '0;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               xfer_q  <= load_xfer;
               state_q <= S_ISSUE;
            end
            S_ISSUE: begin
               if (!lcd_busy) begin
                  data_ready_q <= 1'b1;
                  state_q      <= S_WAIT_HI;
               end
            end
            S_WAIT_HI: if (lcd_busy)  state_q <= S_WAIT_LO;
            S_WAIT_LO: if (!lcd_busy) state_q <= S_NEXT;
            S_NEXT: begin
               if (idx_q == LAST_IDX) begin
                  frame_done_q <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  idx_q   <= idx_q + 4'd1;
                  state_q <= S_LOAD;
               end
            end
            S_DONE: begin
               frame_busy_q <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign lcd_d_in       = xfer_q;
   assign lcd_data_ready = data_ready_q;
   assign frame_busy     = frame_busy_q;
   assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_lcd_value_display.sv
// Bench for lcd_value_display: behavioural lcd busy model, a decimal-text reference model
// checked on every request, and directed frames with hand-written character sequences.
module tb_lcd_value_display;

   logic        clock = 1'b0;
   logic        internal_reset_n;
   logic        enable;
   logic [31:0] value;
   logic        lcd_busy;
   logic [8:0]  lcd_d_in;
   logic        lcd_data_ready;
   logic        frame_busy;
   logic        frame_done;

   int n_vec = 0;
   int n_err = 0;

   logic [8:0] exp_q[$];
   logic [8:0] cur_frame[$];
   logic [8:0] done_frame[$];
   logic [8:0] last_word = '0;
   logic [8:0] pins [3][11];

   int  n_start = 0, n_done = 0, n_dr = 0, cyc = 0;
   int  last_start_cyc = 0, last_done_cyc = 0;
   bit  prev_dr = 1'b0, prev_fb = 1'b0, prev_fd = 1'b0;
   bit  busy_force = 1'b0;

   lcd_value_display #(
      .CLK_FREQ   (150000),
      .REFRESH_MS (1),
      .POS_CMD    (8'hC0),
      .BLANK_LEAD (1'b1)
   ) dut (
      .clock            (clock),
      .internal_reset_n (internal_reset_n),
      .enable           (enable),
      .value            (value),
      .lcd_busy         (lcd_busy),
      .lcd_d_in         (lcd_d_in),
      .lcd_data_ready   (lcd_data_ready),
      .frame_busy       (frame_busy),
      .frame_done       (frame_done)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: got no finish, required finish within 90000 cycles");
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Expected words for one frame, from plain decimal arithmetic.
   task automatic model_frame(input logic [31:0] v);
      logic [31:0] t;
      int          d [10];
      bit          lead;
      t    = v;
      lead = 1'b1;
      exp_q.push_back(9'h0C0);
      for (int i = 9; i >= 0; i--) begin
         d[i] = int'(t % 10);
         t    = t / 10;
      end
      for (int i = 0; i < 10; i++) begin
         if (d[i] != 0 || i == 9) lead = 1'b0;
         exp_q.push_back(lead ? 9'h120 : (9'h130 + 9'(d[i])));
      end
   endtask

   function automatic int get_cnt(input int sel);
      return (sel == 0) ? n_start : (sel == 1) ? n_done : n_dr;
   endfunction

   function automatic logic [8:0] frame_word(input int i);
      return (i < done_frame.size()) ? done_frame[i] : 9'h1FF;
   endfunction

   // sel: 0 = frame starts, 1 = frame_done pulses, 2 = data_ready pulses
   task automatic wait_evt(input int sel, input int target, input int budget, input string name);
      int c;
      c = 0;
      while (get_cnt(sel) < target && c < budget) begin
         @(negedge clock);
         c++;
      end
      if (get_cnt(sel) < target) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout %s: got %0d events, required %0d", name, get_cnt(sel), target);
      end
   endtask

   task automatic tick_frame(input logic [31:0] v, input string name);
      int s0, d0;
      s0 = n_start;
      d0 = n_done;
      @(posedge clock); #1;
      value  = v;
      enable = 1'b1;
      wait_evt(0, s0 + 1, 400, {name, "_start"});
      @(posedge clock); #1;
      enable = 1'b0;
      wait_evt(1, d0 + 1, 800, {name, "_done"});
   endtask

   task automatic pin_frame(input int sel, input string name);
      check({name, "_len"}, 32'(done_frame.size()), 32'd11);
      for (int i = 0; i < 11; i++) check(name, 32'(frame_word(i)), 32'(pins[sel][i]));
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_d_in"},  32'(lcd_d_in),       32'h0);
      check({name, "_dr"},    32'(lcd_data_ready), 32'h0);
      check({name, "_busy"},  32'(frame_busy),     32'h0);
      check({name, "_fdone"}, 32'(frame_done),     32'h0);
   endtask

   // ---------------- lcd core busy model ----------------
   // busy rises 3 cycles after a request and stays high 20 cycles; busy_force holds it high.
   initial begin : busy_model
      int dly, hold;
      dly      = 0;
      hold     = 0;
      lcd_busy = 1'b0;
      forever begin
         @(posedge clock); #2;
         if (lcd_data_ready) begin
            dly = 3;
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) hold = 20;
         end
         lcd_busy = (hold > 0) || busy_force;
         if (hold > 0) hold--;
      end
   end

   // ---------------- scoreboard / compare process ----------------
   always @(negedge clock) begin
      cyc++;
      if (!internal_reset_n) begin
         exp_q.delete();
         cur_frame.delete();
         prev_dr = 1'b0;
         prev_fb = 1'b0;
         prev_fd = 1'b0;
      end else begin
         if (frame_busy && !prev_fb) begin
            n_start++;
            last_start_cyc = cyc;
            cur_frame.delete();
            model_frame(value);
         end
         if (lcd_data_ready) begin
            n_dr++;
            check("req_while_busy", 32'(lcd_busy), 32'h0);
            check("req_double",     32'(prev_dr),  32'h0);
            if (exp_q.size() == 0) begin
               check("req_unexpected", 32'(lcd_d_in), 32'h1FF);
            end else begin
               check("xfer_word", 32'(lcd_d_in), 32'(exp_q.pop_front()));
            end
            cur_frame.push_back(lcd_d_in);
            last_word = lcd_d_in;
         end
         if (lcd_busy && frame_busy && cur_frame.size() > 0) begin
            check("d_in_stable", 32'(lcd_d_in), 32'(last_word));
         end
         if (frame_done) begin
            n_done++;
            last_done_cyc = cyc;
            check("done_single",   32'(prev_fd),          32'h0);
            check("done_all_sent", 32'(exp_q.size()),     32'h0);
            check("done_count",    32'(cur_frame.size()), 32'd11);
            done_frame = cur_frame;
         end
         prev_dr = lcd_data_ready;
         prev_fb = frame_busy;
         prev_fd = frame_done;
      end
   end

   // ---------------- directed sequence ----------------
   initial begin : main
      int s, d, r;
      pins[0] = '{9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120, 9'h120,
                  9'h131, 9'h132, 9'h133, 9'h134, 9'h135};
      pins[1] = '{9'h0C0, 9'h120, 9'h120, 9'h120, 9'h120, 9'h120,
                  9'h120, 9'h120, 9'h120, 9'h120, 9'h130};
      pins[2] = '{9'h0C0, 9'h134, 9'h132, 9'h139, 9'h134, 9'h139,
                  9'h136, 9'h137, 9'h132, 9'h139, 9'h135};

      internal_reset_n = 1'b0;
      enable           = 1'b0;
      value            = '0;
      repeat (2) @(negedge clock);
      check_reset_outputs("reset");
      @(posedge clock); #1;
      internal_reset_n = 1'b1;

      tick_frame(32'd12345, "f12345");
      pin_frame(0, "f12345");
      tick_frame(32'd0, "fzero");
      pin_frame(1, "fzero");
      tick_frame(32'hFFFFFFFF, "fmax");
      pin_frame(2, "fmax");

      // Core busy for 1000 cycles: no request until it falls, then exactly one.
      @(posedge clock); #1;
      busy_force = 1'b1;
      value      = 32'd987;
      enable     = 1'b1;
      s = n_start;
      d = n_done;
      wait_evt(0, s + 1, 400, "hold_start");
      @(posedge clock); #1;
      enable = 1'b0;
      r = n_dr;
      repeat (1000) @(posedge clock);
      #1;
      busy_force = 1'b0;
      check("hold_no_req", 32'(n_dr), 32'(r));
      repeat (4) @(negedge clock);
      check("hold_one_req", 32'(n_dr), 32'(r + 1));
      wait_evt(1, d + 1, 800, "hold_done");

      // value changes during CONVERT and during transfer 5 must not reach the display.
      @(posedge clock); #1;
      value  = 32'd55555;
      enable = 1'b1;
      s = n_start;
      d = n_done;
      wait_evt(0, s + 1, 400, "chg_start");
      @(posedge clock); #1;
      enable = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      value = 32'd7;
      r = n_dr;
      wait_evt(2, r + 5, 400, "chg_xfer5");
      @(posedge clock); #1;
      value = 32'd99999999;
      wait_evt(1, d + 1, 800, "chg_done");
      check("chg_digit6",  32'(frame_word(6)),  32'h135);
      check("chg_digit10", 32'(frame_word(10)), 32'h135);

      // Enable held through a frame: two ticks inside it yield exactly one extra frame.
      @(posedge clock); #1;
      value  = 32'd4242;
      enable = 1'b1;
      s = n_start;
      d = n_done;
      wait_evt(0, s + 1, 400, "tt_start1");
      wait_evt(1, d + 1, 800, "tt_done1");
      wait_evt(0, s + 2, 10, "tt_start2");
      @(posedge clock); #1;
      enable = 1'b0;
      check("tt_gap", 32'(last_start_cyc - last_done_cyc), 32'd2);
      wait_evt(1, d + 2, 800, "tt_done2");
      repeat (600) @(negedge clock);
      check("tt_frames", 32'(n_start - s), 32'd2);

      // Reset in WAIT_LO of transfer 4, then a full frame after release.
      @(posedge clock); #1;
      value  = 32'd12345;
      enable = 1'b1;
      s = n_start;
      d = n_done;
      wait_evt(0, s + 1, 400, "rst_start");
      @(posedge clock); #1;
      enable = 1'b0;
      r = n_dr;
      wait_evt(2, r + 4, 400, "rst_xfer4");
      repeat (8) @(negedge clock);
      check("pre_rst_busy", 32'(frame_busy), 32'h1);
      check("pre_rst_d_in", 32'(lcd_d_in),   32'h120);
      #2;
      internal_reset_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      repeat (3) @(posedge clock);
      #1;
      internal_reset_n = 1'b1;
      check("rst_no_done", 32'(n_done), 32'(d));
      tick_frame(32'd12345, "f_after_rst");
      pin_frame(0, "f_after_rst");
      check("rst_one_done", 32'(n_done), 32'(d + 1));

      check("model_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
